// File: rtl/pipelined_shifter_pkg.sv
// Shared definitions for the pipelined shifter: shift mode encodings and helpers
// that place each barrel-mux level in front of a register stage.
package pipelined_shifter_pkg;

   typedef enum logic [1:0] {
      MODE_SLL = 2'b00,
      MODE_SRL = 2'b01,
      MODE_SRA = 2'b10,
      MODE_ROR = 2'b11
   } shift_mode_e;

   function automatic int shamt_width(input int width);
      return $clog2(width);
   endfunction

   // Register stage whose input logic evaluates mux level `level`.
   function automatic int stage_of(input int level, input int stages, input int levels);
      return (level * stages) / levels;
   endfunction

   // True when `level` is the last mux level feeding its stage register.
   function automatic logic ends_stage(input int level, input int stages, input int levels);
      if (level == levels - 1) begin
         return 1'b1;
      end
      return stage_of(level + 1, stages, levels) != stage_of(level, stages, levels);
   endfunction

endpackage

// File: rtl/shift_level.sv
// One combinational barrel-mux level: moves i_data by 2**LEVEL bits when i_en is set.
// Latency 0, no state, no handshake.
module shift_level
   import pipelined_shifter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int LEVEL = 0
) (
   input  logic [WIDTH-1:0] i_data,
   input  logic [1:0]       i_mode,
   input  logic             i_fill,
   input  logic             i_en,
   output logic [WIDTH-1:0] o_data
);

   localparam int SH = 1 << LEVEL;

   logic [WIDTH-1:0] w_hi_mask;

   // Top SH bits set: the positions vacated by a right shift.
   assign w_hi_mask = ~({WIDTH{1'b1}} >> SH);

   always_comb begin
      o_data = i_data;
      if (i_en) begin
         case (i_mode)
            MODE_SLL: o_data = i_data << SH;
            MODE_SRL: o_data = i_data >> SH;
            MODE_SRA: o_data = (i_data >> SH) | (i_fill ? w_hi_mask : '0);
            MODE_ROR: o_data = (i_data >> SH) | (i_data << (WIDTH - SH));
            default:  o_data = i_data;
         endcase
      end
   end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined SLL/SRL/SRA/ROR unit, latency STAGES cycles, 1 op/cycle sustained.
// Backpressure: outReady low stalls the pipe, bubbles collapse, a full pipe drops inReady.
module pipelined_shifter
   import pipelined_shifter_pkg::*;
#(
   parameter  int WIDTH     = 32,
   parameter  int STAGES    = 2,
   parameter  int TAG_WIDTH = 5,
   localparam int SHW       = shamt_width(WIDTH)
) (
   input  logic                 clock,
   input  logic                 resetN,
   input  logic                 flush,
   input  logic                 inValid,
   output logic                 inReady,
   input  logic [WIDTH-1:0]     inData,
   input  logic [SHW-1:0]       inShamt,
   input  logic [1:0]           inMode,
   input  logic [TAG_WIDTH-1:0] inTag,
   output logic                 outValid,
   input  logic                 outReady,
   output logic [WIDTH-1:0]     outData,
   output logic [TAG_WIDTH-1:0] outTag
);

   localparam int L = SHW;

   logic [STAGES-1:0]    r_vld;
   logic [WIDTH-1:0]     r_data  [STAGES];
   logic [SHW-1:0]       r_shamt [STAGES];
   logic [1:0]           r_mode  [STAGES];
   logic                 r_fill  [STAGES];
   logic [TAG_WIDTH-1:0] r_tag   [STAGES];

   logic [STAGES-1:0]    w_move;
   logic [STAGES-1:0]    w_ready;
   logic [STAGES-1:0]    w_load;
   logic                 w_in_fire;
   logic [WIDTH-1:0]     w_stage_d   [STAGES];
   logic [SHW-1:0]       w_src_shamt [STAGES];
   logic [1:0]           w_src_mode  [STAGES];
   logic                 w_src_fill  [STAGES];
   logic [TAG_WIDTH-1:0] w_src_tag   [STAGES];

   logic [WIDTH-1:0]     w_lvl_in   [L];
   logic [WIDTH-1:0]     w_lvl_out  [L];
   logic [1:0]           w_lvl_mode [L];
   logic [L-1:0]         w_lvl_en;
   logic [L-1:0]         w_lvl_fill;

   // Ready ripples back from the consumer so a full pipe still advances every cycle.
   always_comb begin : handshake
      logic w_down_rdy;
      w_down_rdy = outReady;
      w_move     = '0;
      w_ready    = '0;
      for (int s = STAGES - 1; s >= 0; s--) begin
         w_move[s]  = r_vld[s] && w_down_rdy;
         w_ready[s] = !r_vld[s] || w_move[s];
         w_down_rdy = w_ready[s];
      end
   end

   assign inReady   = !flush && w_ready[0];
   assign w_in_fire = inValid && inReady;

   always_comb begin
      w_load    = '0;
      w_load[0] = w_in_fire;
      for (int s = 1; s < STAGES; s++) begin
         w_load[s] = w_move[s-1];
      end
   end

   for (genvar s = 0; s < STAGES; s++) begin : g_src
      if (s == 0) begin : g_from_in
         assign w_src_shamt[s] = inShamt;
         assign w_src_mode[s]  = inMode;
         assign w_src_fill[s]  = inData[WIDTH-1];
         assign w_src_tag[s]   = inTag;
      end else begin : g_from_reg
         assign w_src_shamt[s] = r_shamt[s-1];
         assign w_src_mode[s]  = r_mode[s-1];
         assign w_src_fill[s]  = r_fill[s-1];
         assign w_src_tag[s]   = r_tag[s-1];
      end
   end

   for (genvar i = 0; i < L; i++) begin : g_lvl
      localparam int S = stage_of(i, STAGES, L);

      if (S == 0) begin : g_ctl_in
         assign w_lvl_en[i]   = inShamt[i];
         assign w_lvl_mode[i] = inMode;
         assign w_lvl_fill[i] = inData[WIDTH-1];
      end else begin : g_ctl_reg
         assign w_lvl_en[i]   = r_shamt[S-1][i];
         assign w_lvl_mode[i] = r_mode[S-1];
         assign w_lvl_fill[i] = r_fill[S-1];
      end

      // First level of a stage reads the previous register, later ones chain.
      if (i == 0) begin : g_din_port
         assign w_lvl_in[i] = inData;
      end else if (stage_of(i - 1, STAGES, L) == S) begin : g_din_chain
         assign w_lvl_in[i] = w_lvl_out[i-1];
      end else begin : g_din_reg
         assign w_lvl_in[i] = r_data[S-1];
      end

      shift_level #(
         .WIDTH (WIDTH),
         .LEVEL (i)
      ) u_level (
         .i_data (w_lvl_in[i]),
         .i_mode (w_lvl_mode[i]),
         .i_fill (w_lvl_fill[i]),
         .i_en   (w_lvl_en[i]),
         .o_data (w_lvl_out[i])
      );

      if (ends_stage(i, STAGES, L)) begin : g_stage_end
         assign w_stage_d[S] = w_lvl_out[i];
      end
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_vld <= '0;
         for (int s = 0; s < STAGES; s++) begin
            r_data[s]  <= '0;
            r_shamt[s] <= '0;
            r_mode[s]  <= '0;
            r_fill[s]  <= 1'b0;
            r_tag[s]   <= '0;
         end
      end else begin
         for (int s = 0; s < STAGES; s++) begin
            if (flush) begin
               r_vld[s] <= 1'b0;
            end else if (w_ready[s]) begin
               r_vld[s] <= w_load[s];
            end
            if (w_load[s]) begin
               r_data[s]  <= w_stage_d[s];
               r_shamt[s] <= w_src_shamt[s];
               r_mode[s]  <= w_src_mode[s];
               r_fill[s]  <= w_src_fill[s];
               r_tag[s]   <= w_src_tag[s];
            end
         end
      end
   end

   assign outValid = r_vld[STAGES-1];
   assign outData  = r_data[STAGES-1];
   assign outTag   = r_tag[STAGES-1];

endmodule

// File: tb/tb_pipelined_shifter.sv
// Bench for pipelined_shifter: several width/depth configurations share one stimulus
// stream; each result is checked against an arithmetic reference held in a per-instance ring.
module tb_pipelined_shifter;

   localparam int N = 6;

   function automatic int cfg_w(input int k);
      case (k)
         4, 5:    return 8;
         default: return 32;
      endcase
   endfunction

   function automatic int cfg_s(input int k);
      case (k)
         0:       return 2;
         1:       return 1;
         2:       return 3;
         3:       return 5;
         4:       return 1;
         default: return 3;
      endcase
   endfunction

   logic        clock = 1'b0;
   logic        resetN;
   logic        flush;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] in_data;
   logic [4:0]  in_shamt;
   logic [1:0]  in_mode;
   logic [4:0]  in_tag;

   logic        in_ready  [N];
   logic        out_valid [N];
   logic [31:0] out_data  [N];
   logic [4:0]  out_tag   [N];

   logic [31:0] exp_d [N][64];
   logic [4:0]  exp_t [N][64];
   int          head  [N];
   int          tail  [N];

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   for (genvar k = 0; k < N; k++) begin : g_dut
      localparam int W  = cfg_w(k);
      localparam int S  = cfg_s(k);
      localparam int SW = $clog2(W);
      logic [W-1:0] od;
      logic [4:0]   ot;
      logic         ir;
      logic         ov;

      pipelined_shifter #(
         .WIDTH     (W),
         .STAGES    (S),
         .TAG_WIDTH (5)
      ) u_dut (
         .clock    (clock),
         .resetN   (resetN),
         .flush    (flush),
         .inValid  (in_valid),
         .inReady  (ir),
         .inData   (in_data[W-1:0]),
         .inShamt  (in_shamt[SW-1:0]),
         .inMode   (in_mode),
         .inTag    (in_tag),
         .outValid (ov),
         .outReady (out_ready),
         .outData  (od),
         .outTag   (ot)
      );

      assign in_ready[k]  = ir;
      assign out_valid[k] = ov;
      assign out_data[k]  = 32'(od);
      assign out_tag[k]   = ot;
   end

   // Reference: plain shift/rotate arithmetic on a w-bit value.
   function automatic logic [31:0] ref_shift(input int w, input logic [31:0] d,
                                             input int sh, input logic [1:0] m);
      logic [63:0]        mask;
      logic [63:0]        x;
      logic [63:0]        r;
      logic signed [63:0] sx;
      mask = (64'd1 << w) - 64'd1;
      x    = {32'd0, d} & mask;
      case (m)
         2'b00: r = x << sh;
         2'b01: r = x >> sh;
         2'b10: begin
            sx = x | (x[w-1] ? ~mask : 64'd0);
            r  = sx >>> sh;
         end
         default: r = (x >> sh) | (x << (w - sh));
      endcase
      return 32'(r & mask);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: sample handshakes before the edge, update the model, advance to the next negedge.
   task automatic tick();
      #1;
      for (int k = 0; k < N; k++) begin
         if (out_valid[k] && out_ready) begin
            chk($sformatf("sb_nonempty[%0d]", k), 64'(head[k] != tail[k]), 64'd1);
            if (head[k] != tail[k]) begin
               chk($sformatf("sb_data[%0d]", k), 64'(out_data[k]), 64'(exp_d[k][head[k] % 64]));
               chk($sformatf("sb_tag[%0d]", k), 64'(out_tag[k]), 64'(exp_t[k][head[k] % 64]));
               head[k]++;
            end
         end
         if (in_valid && in_ready[k]) begin
            exp_d[k][tail[k] % 64] = ref_shift(cfg_w(k), in_data, int'(in_shamt) % cfg_w(k), in_mode);
            exp_t[k][tail[k] % 64] = in_tag;
            tail[k]++;
         end
         if (flush || !resetN) begin
            head[k] = tail[k];
         end
      end
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic directed(input string tag, input logic [31:0] d, input logic [4:0] sh,
                           input logic [1:0] m, input logic [4:0] t, input logic [31:0] expd);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_data   = d;
      in_shamt  = sh;
      in_mode   = m;
      in_tag    = t;
      tick();
      in_valid = 1'b0;
      repeat (cfg_s(0) - 1) tick();
      chk({tag, "_vld"}, 64'(out_valid[0]), 64'd1);
      chk({tag, "_data"}, 64'(out_data[0]), 64'(expd));
      chk({tag, "_tag"}, 64'(out_tag[0]), 64'(t));
      tick();
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 20; c++) tick();
      for (int k = 0; k < N; k++) begin
         chk($sformatf("drain_empty[%0d]", k), 64'(tail[k] - head[k]), 64'd0);
      end
   endtask

   task automatic randomize_inputs();
      in_data  = $urandom;
      in_shamt = 5'($urandom);
      in_mode  = 2'($urandom);
      in_tag   = 5'($urandom);
   endtask

   task automatic random_phase(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 39) == 0);
         randomize_inputs();
         tick();
      end
      flush = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] hold_d;
      logic [4:0]  hold_t;
      resetN    = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_data   = '0;
      in_shamt  = '0;
      in_mode   = '0;
      in_tag    = '0;
      hold_d    = '0;
      hold_t    = '0;
      for (int k = 0; k < N; k++) begin
         head[k] = 0;
         tail[k] = 0;
      end

      repeat (3) @(negedge clock);
      for (int k = 0; k < N; k++) begin
         chk($sformatf("rst_vld[%0d]", k), 64'(out_valid[k]), 64'd0);
         chk($sformatf("rst_data[%0d]", k), 64'(out_data[k]), 64'd0);
         chk($sformatf("rst_tag[%0d]", k), 64'(out_tag[k]), 64'd0);
      end
      resetN = 1'b1;
      tick();
      for (int k = 0; k < N; k++) begin
         chk($sformatf("rst_rdy[%0d]", k), 64'(in_ready[k]), 64'd1);
      end

      // First op: latency is exactly two cycles on the main instance.
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_data   = 32'h0000_0001;
      in_shamt  = 5'd31;
      in_mode   = 2'b00;
      in_tag    = 5'd7;
      tick();
      in_valid = 1'b0;
      chk("lat_early_vld", 64'(out_valid[0]), 64'd0);
      tick();
      chk("lat_vld", 64'(out_valid[0]), 64'd1);
      chk("lat_data", 64'(out_data[0]), 64'h8000_0000);
      chk("lat_tag", 64'(out_tag[0]), 64'd7);
      tick();

      directed("sra4",   32'h8000_0000, 5'd4,  2'b10, 5'd1,  32'hF800_0000);
      directed("srl4",   32'h8000_0000, 5'd4,  2'b01, 5'd2,  32'h0800_0000);
      directed("ror1",   32'h0000_0001, 5'd1,  2'b11, 5'd3,  32'h8000_0000);
      directed("sra31",  32'h8000_0001, 5'd31, 2'b10, 5'd4,  32'hFFFF_FFFF);
      directed("sll0",   32'hA5C3_0F96, 5'd0,  2'b00, 5'd5,  32'hA5C3_0F96);
      directed("srl0",   32'hA5C3_0F96, 5'd0,  2'b01, 5'd6,  32'hA5C3_0F96);
      directed("sra0",   32'hA5C3_0F96, 5'd0,  2'b10, 5'd8,  32'hA5C3_0F96);
      directed("ror0",   32'hA5C3_0F96, 5'd0,  2'b11, 5'd9,  32'hA5C3_0F96);
      directed("ror13",  32'h1234_5678, 5'd13, 2'b11, 5'd10, 32'hB3C0_91A2);
      drain();

      // 16 back-to-back ops: results on 16 consecutive cycles.
      out_ready = 1'b1;
      for (int i = 0; i < 16 + cfg_s(0); i++) begin
         in_valid = (i < 16);
         randomize_inputs();
         #1;
         if (i >= cfg_s(0)) begin
            chk($sformatf("stream_vld[%0d]", i - cfg_s(0)), 64'(out_valid[0]), 64'd1);
         end
         if (i < 16) begin
            chk($sformatf("stream_rdy[%0d]", i), 64'(in_ready[0]), 64'd1);
         end
         tick();
      end
      drain();

      // Backpressure: STAGES accepts, then inReady low and outputs frozen.
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         randomize_inputs();
         #1;
         chk($sformatf("bp_rdy[%0d]", i), 64'(in_ready[0]), 64'(i < cfg_s(0)));
         if (i == cfg_s(0)) begin
            hold_d = out_data[0];
            hold_t = out_tag[0];
         end else if (i > cfg_s(0)) begin
            chk($sformatf("bp_vld[%0d]", i), 64'(out_valid[0]), 64'd1);
            chk($sformatf("bp_data[%0d]", i), 64'(out_data[0]), 64'(hold_d));
            chk($sformatf("bp_tag[%0d]", i), 64'(out_tag[0]), 64'(hold_t));
         end
         tick();
      end
      drain();

      // Flush with two ops in flight: nothing emitted, same-cycle input refused.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      randomize_inputs();
      tick();
      randomize_inputs();
      tick();
      flush = 1'b1;
      randomize_inputs();
      #1;
      chk("flush_rdy", 64'(in_ready[0]), 64'd0);
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      for (int k = 0; k < N; k++) begin
         chk($sformatf("flush_vld[%0d]", k), 64'(out_valid[k]), 64'd0);
      end
      directed("post_flush", 32'h0000_00F0, 5'd4, 2'b01, 5'd11, 32'h0000_000F);
      drain();

      random_phase(300);

      // Asynchronous reset between edges with every pipe holding results.
      in_valid  = 1'b1;
      out_ready = 1'b0;
      in_data   = 32'hC3A5_5A3C;
      in_shamt  = 5'd1;
      in_mode   = 2'b11;
      in_tag    = 5'd21;
      repeat (6) tick();
      chk("pre_rst_vld", 64'(out_valid[0]), 64'd1);
      #2;
      resetN = 1'b0;
      #1;
      for (int k = 0; k < N; k++) begin
         chk($sformatf("arst_vld[%0d]", k), 64'(out_valid[k]), 64'd0);
         chk($sformatf("arst_data[%0d]", k), 64'(out_data[k]), 64'd0);
         chk($sformatf("arst_tag[%0d]", k), 64'(out_tag[k]), 64'd0);
         head[k] = tail[k];
      end
      in_valid = 1'b0;
      @(negedge clock);
      resetN = 1'b1;
      tick();

      random_phase(200);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipelined_shifter.md
Name: pipelined_shifter

Overview:
- Parametrised, pipelined shift unit for the datapath's ALU and immediate paths; generalises the fixed left-shift-by-2 immediate shifter.
- Supports SLL, SRL, SRA and ROR with a variable shift amount over WIDTH bits.
- Spreads the log2(WIDTH) barrel-mux levels over STAGES register stages, with valid/ready handshakes on both sides and full backpressure.
- Carries a tag (e.g. destination register index) alongside each operand.

Parameters:
- WIDTH, 32, data width in bits; power of two, 8..64.
- STAGES, 2, register stages (= latency in cycles); 1..log2(WIDTH).
- TAG_WIDTH, 5, width of the sideband tag carried with each operation.

Ports:
- clock  input  1  single clock, all state rising-edge.
- resetN  input  1  asynchronous active-low reset.
- flush  input  1  synchronous: invalidate all in-flight operations.
- inValid  input  1  operand presented.
- inReady  output  1  unit accepts operand this cycle.
- inData  input  WIDTH  value to shift.
- inShamt  input  log2(WIDTH)  shift amount; only low log2(WIDTH) bits exist, so no masking needed.
- inMode  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- inTag  input  TAG_WIDTH  sideband, returned unchanged.
- outValid  output  1  result available.
- outReady  input  1  consumer accepts result.
- outData  output  WIDTH  shifted result.
- outTag  output  TAG_WIDTH  tag of the result.

Behaviour:
- Reset (resetN low, async): all stage valid bits = 0, data/tag/mode/shamt registers = 0; outValid = 0, outData = 0, outTag = 0. inReady = 1 from the first cycle after release.
- Transfer: input when inValid && inReady; output when outValid && outReady.
- Pipeline: stage k register holds valid, partial data, remaining shamt bits, mode, tag.
- Mux level i (shift by 2^i, i = 0..L-1, L = log2(WIDTH)) is evaluated combinationally before stage floor(i*STAGES/L). The last stage drives outputs directly from registers (no output combinational logic).
- Stage advance rule: stage k loads when stage k is empty or stage k's content moves forward this cycle. The last stage moves when outReady.
  - inReady = !valid[0] || advance[0] (combinational from outReady through the chain).
  - Sustained throughput is 1 op/cycle with outReady held high.
- Latency: an accepted input appears on outValid exactly STAGES cycles later if not stalled.
- Backpressure: outReady low holds outData/outTag stable while outValid is high. Bubbles collapse; a full pipe deasserts inReady.
- Arithmetic:
  - SLL fills with 0.
  - SRL fills with 0.
  - SRA fills with inData[WIDTH-1], captured at input and carried with the operation.
  - ROR rotates right.
  - shamt = 0 passes data unchanged in all modes.
- Boundaries:
  - SRA of a negative value by WIDTH-1 gives all ones.
  - SLL by WIDTH-1 of 1 gives 1 << (WIDTH-1).
  - ROR by 1 of 1 gives MSB set.
- flush: clears all valid bits at the next edge. inReady is forced 0 during a flush cycle, so a same-cycle input is not accepted. outValid is low the cycle after flush. flush and resetN low together behave as reset.
- Reset mid-operation: in-flight results are discarded, never emitted.

Decomposition:
- Shared package: mode encodings (MODE_SLL/SRL/SRA/ROR), a clog2-based SHAMT_WIDTH function, and the stage-assignment function.
- One natural sub-module, shift_level: a single combinational mux level parametrised by WIDTH and level index. It takes data, mode, fill bit and the enable bit, and is instantiated L times.

Test Plan:
- WIDTH=32, STAGES=2: inData=0x0000_0001, SLL, shamt=31, tag=7 -> 2 cycles later outData=0x8000_0000, outTag=7.
- SRA 0x8000_0000 by 4 -> 0xF800_0000. SRL same -> 0x0800_0000. ROR 0x0000_0001 by 1 -> 0x8000_0000. Any mode shamt=0 -> unchanged.
- Back-to-back stream of 16 ops with outReady=1 -> 16 results on 16 consecutive cycles, in order, tags matching.
- Hold outReady=0 for 5 cycles while driving inValid -> inReady falls after STAGES accepts, outData stable. Release -> no loss, no duplication.
- Assert flush with 2 ops in flight -> outValid never rises for them. The next op after flush completes normally.
- Pulse resetN low mid-stream (asynchronous, between edges) -> outValid, outData and outTag go 0 immediately. Sweep STAGES = 1, 3, 5 at WIDTH=32 and WIDTH=8 against a reference model.
